// File: rtl/snn_fifo_pkg.sv
// Shared types and constants for the spike FIFO dispatch path.
// Holds the dispatcher FSM encoding and the FIFO geometry seen by software.
package snn_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } dispatch_state_e;

  localparam int IN_FIFO_DEPTH  = 512;
  localparam int OUT_FIFO_DEPTH = 256;
  localparam int DATA_W         = 32;

endpackage

// File: rtl/fifo_dispatch_ctrl.sv
// Frame sequencer: streams cfg_num_words input words per timestep into the SNN
// core, collects one result per timestep into the output FIFO, cfg_timesteps times.
module fifo_dispatch_ctrl #(
  parameter int DATA_W = snn_fifo_pkg::DATA_W,
  parameter int WCNT_W = 10,
  parameter int TS_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WCNT_W-1:0] cfg_num_words,
  input  logic [TS_W-1:0]   cfg_timesteps,
  input  logic              in_fifo_empty,
  input  logic [DATA_W-1:0] in_fifo_rdata,
  output logic              in_fifo_pop,
  output logic              core_valid,
  output logic [DATA_W-1:0] core_data,
  output logic              core_last,
  input  logic              core_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              out_fifo_full,
  output logic              out_fifo_push,
  output logic [DATA_W-1:0] out_fifo_wdata,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [TS_W-1:0]   ts_index
);

  import snn_fifo_pkg::*;

  dispatch_state_e   state, state_nxt;
  logic [WCNT_W-1:0] word_cnt, num_words;
  logic [TS_W-1:0]   ts_cnt, timesteps;
  logic              cfg_zero, last_ts;

  assign cfg_zero       = (cfg_num_words == '0) || (cfg_timesteps == '0);
  assign last_ts        = (ts_cnt == timesteps - TS_W'(1));
  assign core_data      = in_fifo_rdata;
  assign out_fifo_wdata = res_data;
  assign busy           = (state != IDLE);
  assign ts_index       = ts_cnt;

  always_comb begin
    state_nxt     = state;
    core_valid    = 1'b0;
    core_last     = 1'b0;
    in_fifo_pop   = 1'b0;
    res_ready     = 1'b0;
    out_fifo_push = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cfg_zero) state_nxt = SEND;
      end
      SEND: begin
        core_valid  = !in_fifo_empty;
        core_last   = (word_cnt == num_words - WCNT_W'(1));
        in_fifo_pop = core_valid && core_ready;
        if (in_fifo_pop && core_last) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        res_ready     = !out_fifo_full;
        out_fifo_push = res_valid && res_ready;
        if (out_fifo_push) state_nxt = last_ts ? DONE : SEND;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a done that would fire this cycle.
    if (abort) begin
      state_nxt     = IDLE;
      core_valid    = 1'b0;
      in_fifo_pop   = 1'b0;
      res_ready     = 1'b0;
      out_fifo_push = 1'b0;
      done          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_cnt  <= '0;
      ts_cnt    <= '0;
      num_words <= '0;
      timesteps <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= 1'b0;
      if (abort) begin
        word_cnt <= '0;
        ts_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && cfg_zero) begin
              cfg_err <= 1'b1;
            end else if (start) begin
              num_words <= cfg_num_words;
              timesteps <= cfg_timesteps;
              word_cnt  <= '0;
              ts_cnt    <= '0;
            end
          end
          SEND: begin
            if (in_fifo_pop) word_cnt <= core_last ? '0 : word_cnt + WCNT_W'(1);
          end
          WAIT_RES: begin
            if (out_fifo_push && !last_ts) ts_cnt <= ts_cnt + TS_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_dispatch_ctrl.sv
// Directed bench for fifo_dispatch_ctrl with a queue-backed input FIFO model
// and recorded pops/pushes compared against hand-computed expectations.
module tb_fifo_dispatch_ctrl;

  localparam int DATA_W = 32;
  localparam int WCNT_W = 10;
  localparam int TS_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort;
  logic [WCNT_W-1:0] cfg_num_words;
  logic [TS_W-1:0]   cfg_timesteps;
  logic              in_fifo_empty;
  logic [DATA_W-1:0] in_fifo_rdata;
  logic              in_fifo_pop;
  logic              core_valid;
  logic [DATA_W-1:0] core_data;
  logic              core_last;
  logic              core_ready;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              out_fifo_full;
  logic              out_fifo_push;
  logic [DATA_W-1:0] out_fifo_wdata;
  logic              busy, done, cfg_err;
  logic [TS_W-1:0]   ts_index;

  fifo_dispatch_ctrl #(.DATA_W(DATA_W), .WCNT_W(WCNT_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_words(cfg_num_words), .cfg_timesteps(cfg_timesteps),
    .in_fifo_empty(in_fifo_empty), .in_fifo_rdata(in_fifo_rdata), .in_fifo_pop(in_fifo_pop),
    .core_valid(core_valid), .core_data(core_data), .core_last(core_last), .core_ready(core_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .out_fifo_full(out_fifo_full), .out_fifo_push(out_fifo_push), .out_fifo_wdata(out_fifo_wdata),
    .busy(busy), .done(done), .cfg_err(cfg_err), .ts_index(ts_index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] inq[$];
  logic [DATA_W-1:0] popped[$];
  logic [DATA_W-1:0] pushed[$];
  logic [7:0]        last_mask;
  int  empty_hold, full_hold, stall_at, abort_at, full_on_last;
  bit  rdy_toggle, res_auto, res_pend;
  int  res_seq, done_cnt, err_cnt, busy_cnt, viol, blocked, ts_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    popped.delete(); pushed.delete();
    last_mask = '0; empty_hold = 0; full_hold = 0; stall_at = -1; abort_at = -1;
    full_on_last = 0; rdy_toggle = 0; res_auto = 1; res_pend = 0; res_seq = 0;
    done_cnt = 0; err_cnt = 0; busy_cnt = 0; viol = 0; blocked = 0; ts_max = 0;
  endtask

  // One clock: drive inputs from the models, sample after settling, then advance.
  task automatic tick();
    in_fifo_empty = (inq.size() == 0) || (empty_hold > 0);
    in_fifo_rdata = (inq.size() != 0) ? inq[0] : 32'hDEAD_BEEF;
    if (empty_hold > 0) empty_hold--;
    core_ready    = rdy_toggle ? !core_ready : 1'b1;
    res_valid     = res_pend;
    res_data      = 32'hA000_0000 + res_seq;
    out_fifo_full = (full_hold > 0);
    if (full_hold > 0) full_hold--;
    #1;
    if (in_fifo_pop && (in_fifo_empty || !core_ready || abort)) viol++;
    if (out_fifo_push && (out_fifo_full || !res_valid || abort)) viol++;
    if (res_valid && !res_ready) blocked++;
    if (done) done_cnt++;
    if (cfg_err) err_cnt++;
    if (busy) busy_cnt++;
    if (int'(ts_index) > ts_max) ts_max = int'(ts_index);
    if (in_fifo_pop) begin
      if (core_last && popped.size() < 8) last_mask[popped.size()] = 1'b1;
      popped.push_back(core_data);
      void'(inq.pop_front());
      if (core_last && res_auto) begin
        res_pend = 1;
        full_hold = full_on_last;
      end
      if (popped.size() == stall_at) empty_hold = 5;
    end
    if (out_fifo_push) begin
      pushed.push_back(out_fifo_wdata);
      res_pend = 0;
      res_seq++;
    end
    @(posedge clk);
    #1;
    abort = (popped.size() == abort_at);
    if (abort) abort_at = -1;
  endtask

  task automatic preload(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) inq.push_back(base + i);
  endtask

  task automatic launch(input int nw, input int ts);
    cfg_num_words = WCNT_W'(nw);
    cfg_timesteps = TS_W'(ts);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; cfg_num_words = '0; cfg_timesteps = '0;
    in_fifo_empty = 0; in_fifo_rdata = '0; core_ready = 1; res_valid = 1;
    res_data = '0; out_fifo_full = 0;
    clear_rec();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, cfg_err}, 0);
    check("rst_ts_index", ts_index, 0);
    check("rst_send_outs", {in_fifo_pop, core_valid, core_last}, 0);
    check("rst_res_outs", {res_ready, out_fifo_push}, 0);
    res_valid = 0;
    rst = 1'b0;
    tick();

    // Basic frame: 4 words x 2 timesteps.
    clear_rec();
    preload(8, 32'h100);
    launch(4, 2);
    check("t1_busy_after_start", busy, 1);
    check("t1_ts0", ts_index, 0);
    run_to_done(100);
    check("t1_busy_after_done", busy, 0);
    tick();
    check("t1_done_cnt", done_cnt, 1);
    check("t1_pops", popped.size(), 8);
    for (int i = 0; i < popped.size() && i < 8; i++)
      check($sformatf("t1_word%0d", i), popped[i], 32'h100 + i);
    check("t1_last_mask", last_mask, 8'b1000_1000);
    check("t1_pushes", pushed.size(), 2);
    if (pushed.size() == 2) begin
      check("t1_res0", pushed[0], 32'hA000_0000);
      check("t1_res1", pushed[1], 32'hA000_0001);
    end
    check("t1_ts_max", ts_max, 1);
    check("t1_viol", viol, 0);

    // Empty-FIFO stall and toggling core_ready.
    clear_rec();
    preload(8, 32'h200);
    stall_at = 2;
    rdy_toggle = 1;
    launch(4, 2);
    run_to_done(200);
    check("t2_done", done_cnt, 1);
    check("t2_pops", popped.size(), 8);
    for (int i = 0; i < popped.size() && i < 8; i++)
      check($sformatf("t2_word%0d", i), popped[i], 32'h200 + i);
    check("t2_last_mask", last_mask, 8'b1000_1000);
    check("t2_pushes", pushed.size(), 2);
    check("t2_viol", viol, 0);
    rdy_toggle = 0;

    // Output FIFO full for 10 cycles while a result is offered.
    clear_rec();
    preload(1, 32'h300);
    full_on_last = 10;
    launch(1, 1);
    run_to_done(100);
    check("t3_blocked", blocked, 10);
    check("t3_pushes", pushed.size(), 1);
    if (pushed.size() == 1) check("t3_res", pushed[0], 32'hA000_0000);
    check("t3_done", done_cnt, 1);
    check("t3_viol", viol, 0);

    // Zero word count is rejected.
    clear_rec();
    preload(2, 32'h400);
    launch(0, 2);
    repeat (3) tick();
    check("t4_cfg_err", err_cnt, 1);
    check("t4_busy", busy_cnt, 0);
    check("t4_pops", popped.size(), 0);
    inq.delete();

    // Abort after 2 of 4 words, then a fresh single-timestep frame.
    clear_rec();
    preload(8, 32'h500);
    abort_at = 2;
    launch(4, 2);
    repeat (6) tick();
    check("t5_busy", busy, 0);
    check("t5_pops", popped.size(), 2);
    check("t5_done", done_cnt, 0);
    check("t5_viol", viol, 0);
    popped.delete();
    launch(4, 1);
    check("t5_ts_restart", ts_index, 0);
    run_to_done(100);
    check("t5_done2", done_cnt, 1);
    check("t5_pops2", popped.size(), 4);
    if (popped.size() > 0) check("t5_first_word", popped[0], 32'h502);
    check("t5_pushes2", pushed.size(), 1);
    inq.delete();

    // Asynchronous reset while waiting for a result.
    clear_rec();
    preload(2, 32'h600);
    res_auto = 0;
    launch(2, 1);
    repeat (3) tick();
    check("t6_wait_busy", busy, 1);
    res_valid = 1; out_fifo_full = 0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_outs", {res_ready, out_fifo_push, core_valid, in_fifo_pop, done}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_pend = 1;
    tick();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_pushes", pushed.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
